// File: rtl/arbitro_rr_8b_32b_pkg.sv
// Shared definitions for the round-robin front end of the 8b->32b converter.
//   BURST_LEN : bytes per granted burst (one 32-bit word)
//   DATA_W    : converter byte width
//   state_t   : arbiter FSM encoding
package arb_8b_32b_defs;

    localparam int BURST_LEN = 4;
    localparam int DATA_W    = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/arbitro_rr_8b_32b_rr_pick.sv
// Combinational round-robin priority encoder.
//   req     : request vector, one bit per requester
//   pointer : index with highest priority this round
//   winner  : first set req bit scanning upward from pointer, wrapping
//   any_req : at least one request is set
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  pointer,
    output logic [ID_W-1:0]  winner,
    output logic             any_req
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [ID_W:0]      sum;
    logic               found;

    // Doubling the vector turns the wrap-around scan into a plain
    // lowest-bit search on the rotated copy.
    assign dbl     = {req, req};
    assign rot     = N_REQ'(dbl >> pointer);
    assign any_req = |req;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, pointer} + (ID_W+1)'(k);
                if (sum >= (ID_W+1)'(N_REQ))
                    sum = sum - (ID_W+1)'(N_REQ);
                winner = sum[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_8b_32b.sv
// Round-robin arbiter sharing one 8b->32b converter among N_REQ byte streams.
// Each grant lasts exactly one 4-byte word so the converter stays aligned.
//   clk_4f     : byte-rate clock
//   reset      : synchronous, active-high
//   req        : per-requester "full word ready"
//   data_req   : requester bytes, lane i at [i*DATA_W +: DATA_W]
//   grant      : one-hot, requester presents its next byte while high
//   valid_out  : byte valid to converter (one cycle after grant)
//   data_out   : byte to converter
//   lane_id    : owner of the current byte
//   word_start : first byte of each word
module arbitro_rr_8b_32b #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = arb_8b_32b_defs::DATA_W,
    parameter int ID_W   = 2
) (
    input  logic                    clk_4f,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_req,
    output logic [N_REQ-1:0]        grant,
    output logic                    valid_out,
    output logic [DATA_W-1:0]       data_out,
    output logic [ID_W-1:0]         lane_id,
    output logic                    word_start
);

    import arb_8b_32b_defs::*;

    localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

    state_t                       state, state_nxt;
    logic [1:0]                   cnt, cnt_nxt;
    logic [ID_W-1:0]              ptr, ptr_nxt;
    logic [ID_W-1:0]              winner, winner_nxt;
    logic [ID_W-1:0]              ptr_inc, pick_ptr, pick;
    logic                         any_req, last_beat;
    logic [N_REQ-1:0][DATA_W-1:0] lanes;

    assign lanes     = data_req;
    assign last_beat = (state == ST_BURST) && (cnt == LAST_BEAT);
    assign ptr_inc   = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
    // On the last beat the next winner is chosen with the already-advanced
    // pointer, so back-to-back words rotate without an idle cycle.
    assign pick_ptr  = last_beat ? ptr_inc : ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req     (req),
        .pointer (pick_ptr),
        .winner  (pick),
        .any_req (any_req)
    );

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ptr    <= '0;
            winner <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ptr    <= ptr_nxt;
            winner <= winner_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ptr_nxt    = ptr;
        winner_nxt = winner;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt  = ST_BURST;
                    cnt_nxt    = '0;
                    winner_nxt = pick;
                end
            end
            ST_BURST: begin
                cnt_nxt = cnt + 2'd1;
                if (cnt == LAST_BEAT) begin
                    ptr_nxt = ptr_inc;
                    if (any_req) begin
                        winner_nxt = pick;
                        cnt_nxt    = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        grant = '0;
        if (state == ST_BURST)
            grant[winner] = 1'b1;
    end

    // One-cycle registered datapath: the byte presented under grant is
    // forwarded on the next cycle with its lane tag.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            lane_id    <= '0;
            word_start <= 1'b0;
        end else if (state == ST_BURST) begin
            valid_out  <= 1'b1;
            data_out   <= lanes[winner];
            lane_id    <= winner;
            word_start <= (cnt == 2'd0);
        end else begin
            valid_out  <= 1'b0;
            word_start <= 1'b0;
        end
    end

endmodule
